// File: rtl/nes_bus_pkg.sv
// Purpose: shared NES CPU-bus types and register addresses for bus initiators.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: dma_state_t (OAM DMA sequencer states), OAMDMA_ADDR, OAMDATA_ADDR.
package nes_bus_pkg;

    // OAM DMA sequencer states; 3 bits covers all six.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HALT  = 3'd1,
        DUMMY = 3'd2,
        ALIGN = 3'd3,
        READ  = 3'd4,
        WRITE = 3'd5
    } dma_state_t;

    // CPU write here starts a sprite DMA; the write data is the source page.
    localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
    // PPU OAM data port; every copied byte is written here.
    localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// Purpose: NES sprite DMA initiator and CPU/DMA bus mux; copies page {pg,00..FF} to DEST_ADDR.
// Latency: trigger to rdy=1 is HALT(>=1) + DUMMY(1) + ALIGN(0/1) + 512 cycles.
// Backpressure: halts the CPU with rdy=0 while the DMA owns the bus; no stall on the memory side.
// Ports:
//   clk_ph1, rst (sync, active-low)        : clock and reset
//   cpu_Addr_bus/cpu_Data_bus_out/cpu_R_nW : CPU-side bus request
//   Data_bus_in                            : memory read data for the current Addr_bus
//   Addr_bus/Data_bus_out/R_nW             : muxed bus towards memory/IO decode
//   rdy                                    : CPU advance enable (registered)
//   dma_active                             : DMA owns the bus (DUMMY/ALIGN/READ/WRITE)
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = OAMDMA_ADDR,
    parameter logic [15:0] DEST_ADDR = OAMDATA_ADDR
) (
    input  logic        clk_ph1,
    input  logic        rst,
    input  logic [15:0] cpu_Addr_bus,
    input  logic [7:0]  cpu_Data_bus_out,
    input  logic        cpu_R_nW,
    input  logic [7:0]  Data_bus_in,
    output logic [15:0] Addr_bus,
    output logic [7:0]  Data_bus_out,
    output logic        R_nW,
    output logic        rdy,
    output logic        dma_active
);

    dma_state_t  r_state;
    dma_state_t  w_next_state;
    logic [7:0]  r_page;
    logic [7:0]  r_idx;
    logic [7:0]  r_latch;
    logic        r_parity;
    logic        r_rdy;
    logic        w_trigger;
    logic        w_last_byte;

    assign w_trigger   = (r_state == IDLE) && !cpu_R_nW && (cpu_Addr_bus == TRIG_ADDR);
    assign w_last_byte = (r_idx == 8'hFF);

    // State, counters and the parity toggle. rdy is registered from the
    // next state so it drops the cycle after the trigger and rises the
    // cycle after the final WRITE.
    always_ff @(posedge clk_ph1) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_page   <= 8'h00;
            r_idx    <= 8'h00;
            r_latch  <= 8'h00;
            r_parity <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            r_state  <= w_next_state;
            r_parity <= ~r_parity;
            r_rdy    <= (w_next_state == IDLE);
            if (w_trigger) begin
                r_page <= cpu_Data_bus_out;
                r_idx  <= 8'h00;
            end
            if (r_state == READ) begin
                r_latch <= Data_bus_in;
            end
            // idx is 8 bits wide so it can never carry into the page.
            if ((r_state == WRITE) && !w_last_byte) begin
                r_idx <= r_idx + 8'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_trigger) w_next_state = HALT;
            end
            HALT: begin
                // The CPU can only be stopped on a read cycle; let pending writes drain.
                if (cpu_R_nW) w_next_state = DUMMY;
            end
            DUMMY: begin
                // r_parity is the current cycle; the next cycle's parity is ~r_parity.
                // READ must begin on an even cycle, so burn one ALIGN when the next would be odd.
                if (!r_parity) w_next_state = ALIGN;
                else           w_next_state = READ;
            end
            ALIGN: begin
                w_next_state = READ;
            end
            READ: begin
                w_next_state = WRITE;
            end
            WRITE: begin
                if (w_last_byte) w_next_state = IDLE;
                else             w_next_state = READ;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Bus mux: CPU pass-through in IDLE/HALT, DMA-driven otherwise.
    // DUMMY/ALIGN re-read the CPU's held address, which is side-effect free.
    always_comb begin
        Addr_bus     = cpu_Addr_bus;
        Data_bus_out = cpu_Data_bus_out;
        R_nW         = cpu_R_nW;
        case (r_state)
            DUMMY, ALIGN: begin
                Addr_bus     = cpu_Addr_bus;
                Data_bus_out = r_latch;
                R_nW         = 1'b1;
            end
            READ: begin
                Addr_bus     = {r_page, r_idx};
                Data_bus_out = r_latch;
                R_nW         = 1'b1;
            end
            WRITE: begin
                Addr_bus     = DEST_ADDR;
                Data_bus_out = r_latch;
                R_nW         = 1'b0;
            end
            default: begin
                Addr_bus     = cpu_Addr_bus;
                Data_bus_out = cpu_Data_bus_out;
                R_nW         = cpu_R_nW;
            end
        endcase
    end

    assign rdy        = r_rdy;
    assign dma_active = (r_state == DUMMY) || (r_state == ALIGN) ||
                        (r_state == READ)  || (r_state == WRITE);

endmodule

// File: tb/tb_oam_dma.sv
// Purpose: self-checking bench for oam_dma with a write scoreboard and latency checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_oam_dma;

    logic        clk_ph1;
    logic        rst;
    logic [15:0] cpu_Addr_bus;
    logic [7:0]  cpu_Data_bus_out;
    logic        cpu_R_nW;
    logic [7:0]  Data_bus_in;
    logic [15:0] Addr_bus;
    logic [7:0]  Data_bus_out;
    logic        R_nW;
    logic        rdy;
    logic        dma_active;

    oam_dma dut (
        .clk_ph1          (clk_ph1),
        .rst              (rst),
        .cpu_Addr_bus     (cpu_Addr_bus),
        .cpu_Data_bus_out (cpu_Data_bus_out),
        .cpu_R_nW         (cpu_R_nW),
        .Data_bus_in      (Data_bus_in),
        .Addr_bus         (Addr_bus),
        .Data_bus_out     (Data_bus_out),
        .R_nW             (R_nW),
        .rdy              (rdy),
        .dma_active       (dma_active)
    );

    initial clk_ph1 = 1'b0;
    always #5 clk_ph1 = ~clk_ph1;

    // Memory: each byte's contents are its low address byte XOR 5A.
    assign Data_bus_in = Addr_bus[7:0] ^ 8'h5A;

    // Cycle parity as defined for the bus: 0 on the first cycle after reset.
    logic tb_par;
    always @(posedge clk_ph1) begin
        if (!rst) tb_par <= 1'b0;
        else      tb_par <= ~tb_par;
    end

    typedef struct packed {
        logic [15:0] rd_addr;
        logic [7:0]  wr_dat;
    } exp_t;

    exp_t exp_q[$];
    int   lat_q[$];

    int n_vec = 0;
    int n_err = 0;
    bit skip_lat = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every DMA write and checks rdy-low duration.
    int          low_cnt = 0;
    bit          prev_low = 0;
    logic [15:0] prev_addr = 16'h0;
    logic        prev_par = 1'b0;
    always @(negedge clk_ph1) begin
        exp_t e;
        if (rdy === 1'b0) begin
            low_cnt++;
        end else if (prev_low) begin
            if (skip_lat) begin
                skip_lat = 0;
            end else if (lat_q.size() == 0) begin
                chk("rdy_rise_unexpected", 32'(low_cnt), 32'hFFFF_FFFF);
            end else begin
                chk("rdy_low_cycles", 32'(low_cnt), 32'(lat_q.pop_front()));
            end
            low_cnt = 0;
        end
        prev_low = (rdy === 1'b0);

        if (dma_active === 1'b1 && R_nW === 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("write_unexpected", {16'h0, Addr_bus}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {16'h0, Addr_bus}, 32'h2004);
                chk("wr_data", {24'h0, Data_bus_out}, {24'h0, e.wr_dat});
                chk("rd_addr", {16'h0, prev_addr}, {16'h0, e.rd_addr});
                chk("read_parity", {31'h0, prev_par}, 32'h0);
            end
        end
        prev_addr = Addr_bus;
        prev_par  = tb_par;
    end

    // Issue a trigger in a cycle of parity p_t, hold h_extra pending CPU writes,
    // then check the DUMMY cycle. lat < 0 means the run will be aborted.
    task automatic start_dma(input logic [7:0] page, input int h_extra,
                             input logic p_t, input int lat);
        for (int k = 0; k < 4; k++) begin
            if (tb_par == p_t) break;
            @(posedge clk_ph1); #1;
        end
        chk("trigger_parity", {31'h0, tb_par}, {31'h0, p_t});
        for (int i = 0; i < 256; i++) begin
            exp_t e;
            e.rd_addr = {page, 8'(i)};
            e.wr_dat  = 8'(i) ^ 8'h5A;
            exp_q.push_back(e);
        end
        if (lat >= 0) lat_q.push_back(lat);
        cpu_Addr_bus     = 16'h4014;
        cpu_Data_bus_out = page;
        cpu_R_nW         = 1'b0;
        @(posedge clk_ph1); #1;
        chk("halt_rdy", {31'h0, rdy}, 32'h0);
        chk("halt_dma_active", {31'h0, dma_active}, 32'h0);
        for (int k = 0; k < h_extra; k++) begin
            cpu_Addr_bus     = 16'h0700 + 16'(k);
            cpu_Data_bus_out = 8'(k);
            cpu_R_nW         = 1'b0;
            #1;
            chk("halt_pass_addr", {16'h0, Addr_bus}, 32'h0700 + 32'(k));
            chk("halt_pass_rnw", {31'h0, R_nW}, 32'h0);
            @(posedge clk_ph1); #1;
            chk("halt_hold", {30'h0, dma_active, rdy}, 32'h0);
        end
        cpu_Addr_bus     = 16'hC123;
        cpu_Data_bus_out = 8'h00;
        cpu_R_nW         = 1'b1;
        @(posedge clk_ph1); #1;
        chk("dummy_active", {31'h0, dma_active}, 32'h1);
        chk("dummy_addr", {16'h0, Addr_bus}, 32'hC123);
        chk("dummy_rnw", {31'h0, R_nW}, 32'h1);
    endtask

    task automatic finish_dma();
        for (int k = 0; k < 700; k++) begin
            if (rdy === 1'b1) break;
            @(posedge clk_ph1); #1;
        end
        chk("rdy_return", {31'h0, rdy}, 32'h1);
        cpu_Data_bus_out = 8'h77;
        #1;
        chk("idle_dma_active", {31'h0, dma_active}, 32'h0);
        chk("idle_pass_addr", {16'h0, Addr_bus}, 32'hC123);
        chk("idle_pass_data", {24'h0, Data_bus_out}, 32'h77);
        chk("idle_pass_rnw", {31'h0, R_nW}, 32'h1);
        chk("all_writes_seen", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        bit found;
        rst              = 1'b0;
        cpu_Addr_bus     = 16'h1234;
        cpu_Data_bus_out = 8'h00;
        cpu_R_nW         = 1'b1;
        repeat (3) @(posedge clk_ph1);
        #1;
        chk("reset_rdy", {31'h0, rdy}, 32'h1);
        chk("reset_dma_active", {31'h0, dma_active}, 32'h0);
        chk("reset_addr", {16'h0, Addr_bus}, 32'h1234);
        chk("reset_rnw", {31'h0, R_nW}, 32'h1);
        rst = 1'b1;
        @(posedge clk_ph1); #1;

        // Even alignment: trigger in an odd cycle, no ALIGN.
        start_dma(8'h02, 0, 1'b1, 514);
        finish_dma();
        // Odd alignment: one ALIGN cycle.
        start_dma(8'h02, 0, 1'b0, 515);
        finish_dma();
        // Two pending CPU writes stretch HALT to 3 cycles.
        start_dma(8'h05, 2, 1'b1, 516);
        finish_dma();
        // Top page.
        start_dma(8'hFF, 0, 1'b1, 514);
        finish_dma();

        // Reset during WRITE of idx 40 (data 40^5A = 1A).
        start_dma(8'h11, 0, 1'b1, -1);
        found = 0;
        for (int k = 0; k < 300; k++) begin
            if (dma_active === 1'b1 && R_nW === 1'b0 && Data_bus_out == 8'h1A) begin
                found = 1;
                break;
            end
            @(posedge clk_ph1); #1;
        end
        chk("abort_point_found", {31'h0, found}, 32'h1);
        rst = 1'b0;
        @(posedge clk_ph1); #1;
        exp_q.delete();
        skip_lat = 1;
        chk("abort_rdy", {31'h0, rdy}, 32'h1);
        chk("abort_dma_active", {31'h0, dma_active}, 32'h0);
        chk("abort_pass_addr", {16'h0, Addr_bus}, 32'hC123);
        rst = 1'b1;
        @(posedge clk_ph1); #1;
        chk("abort_no_resume", {30'h0, dma_active, rdy}, 32'h1);
        start_dma(8'h03, 0, 1'b0, 515);
        finish_dma();

        repeat (3) @(posedge clk_ph1);
        chk("latency_checks_done", 32'(lat_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
